process_switch_ctrl: RTL and testbench

Context-switch controller that sits directly upstream of the register bank and owns its process-bank and bookkeeping control lines. It tracks whether the core is running the operating system (bank 0) or a user process (bank 1), enforces a retired-instruction time quantum on the user process, and sequences launch, preemption and termination. On every switch it redirects the program counter and pulses the bank's PC-save (`change_so`) or end-of-process (`end_proc`) strobes.

---
 rtl/process_switch_ctrl_pkg.sv | 30 +++
 rtl/process_switch_ctrl_if.sv | 31 +++
 rtl/process_switch_ctrl_quantum_timer.sv | 29 ++
 rtl/process_switch_ctrl.sv | 121 ++++++++++++
 tb/tb_process_switch_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/process_switch_ctrl_pkg.sv
// Shared definitions for the context-switch controller and the register bank.
//   state_t            : controller FSM state encoding (3 bits)
//   BANK_SO/BANK_PROC  : register-bank select values (OS bank / user bank)
//   REG_*              : register indices the bank uses for bookkeeping
//   reads_proc_bank()  : true in the states where the user bank is read
package jups_pkg;

    typedef enum logic [2:0] {
        SO_RUN   = 3'd0,
        LAUNCH   = 3'd1,
        PROC_RUN = 3'd2,
        PREEMPT  = 3'd3,
        FINISH   = 3'd4
    } state_t;

    localparam logic BANK_SO   = 1'b0;
    localparam logic BANK_PROC = 1'b1;

    localparam int REG_RA       = 30;
    localparam int REG_SAVED_PC = 26;
    localparam int REG_END      = 25;

    // The user bank is read only while the user process is actually running
    // (including its launch cycle); on the way out the OS bank is read again
    // while the user bank is still being written.
    function automatic logic reads_proc_bank(input state_t s);
        return (s == LAUNCH) || (s == PROC_RUN);
    endfunction

endpackage

// File: rtl/process_switch_ctrl_if.sv
// Bundle between the core/register bank and the context-switch controller.
//   master : core side, drives launch/halt/retire requests and the current PC
//   slave  : controller side, drives bank selects, strobes and PC redirect
interface process_switch_ctrl_if #(
    parameter int PC_WIDTH = 32
);
    logic                exec_proc;
    logic [PC_WIDTH-1:0] proc_entry;
    logic                halt_proc;
    logic                instr_retire;
    logic [PC_WIDTH-1:0] ProgramCounter;
    logic                select_proc_reg_read;
    logic                select_proc_reg_write;
    logic                change_so;
    logic                end_proc;
    logic                pc_load;
    logic [PC_WIDTH-1:0] pc_next;
    logic                user_mode;

    modport master (
        output exec_proc, proc_entry, halt_proc, instr_retire, ProgramCounter,
        input  select_proc_reg_read, select_proc_reg_write, change_so,
               end_proc, pc_load, pc_next, user_mode
    );

    modport slave (
        input  exec_proc, proc_entry, halt_proc, instr_retire, ProgramCounter,
        output select_proc_reg_read, select_proc_reg_write, change_so,
               end_proc, pc_load, pc_next, user_mode
    );
endinterface

// File: rtl/process_switch_ctrl_quantum_timer.sv
// Retired-instruction quantum counter for the user process.
//   clk, srst : clock and synchronous active-high reset
//   load      : reload the counter with LOAD_VALUE (QUANTUM - 1)
//   dec       : one instruction retired; decrement
//   expired   : counter is at zero, i.e. the next retire ends the quantum
module quantum_timer #(
    parameter logic [31:0] LOAD_VALUE = 32'd1023
) (
    input  logic clk,
    input  logic srst,
    input  logic load,
    input  logic dec,
    output logic expired
);
    logic [31:0] qcnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            qcnt_reg <= 32'd0;
        end else if (load) begin
            qcnt_reg <= LOAD_VALUE;
        end else if (dec && (qcnt_reg != 32'd0)) begin
            // Guarded so the count can never wrap below zero.
            qcnt_reg <= qcnt_reg - 32'd1;
        end
    end

    assign expired = (qcnt_reg == 32'd0);
endmodule

// File: rtl/process_switch_ctrl.sv
// Context-switch controller between the OS (bank 0) and one user process
// (bank 1). Launches the process, preempts it after QUANTUM retired
// instructions, terminates it on halt, and redirects the PC on each switch.
//   Clock, Reset : clock, synchronous active-high reset
//   bus (slave)  : launch/halt/retire requests and PC in; bank selects,
//                  change_so/end_proc strobes, pc_load/pc_next, user_mode out
module process_switch_ctrl
    import jups_pkg::*;
#(
    parameter longint unsigned QUANTUM  = 1024,
    parameter int              PC_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    process_switch_ctrl_if.slave  bus
);
    localparam logic [31:0] QCNT_INIT = 32'(QUANTUM - 1);

    state_t              state_reg;
    state_t              state_next;
    logic [PC_WIDTH-1:0] so_resume_reg;
    // Holds the user entry PC from launch request until the LAUNCH cycle,
    // then the OS resume PC for PREEMPT/FINISH; outputs are pure decode.
    logic [PC_WIDTH-1:0] pc_next_reg;
    logic                timer_load;
    logic                timer_dec;
    logic                timer_expired;

    quantum_timer #(
        .LOAD_VALUE (QCNT_INIT)
    ) u_quantum_timer (
        .clk     (Clock),
        .srst    (Reset),
        .load    (timer_load),
        .dec     (timer_dec),
        .expired (timer_expired)
    );

    // Next-state logic. Halt has priority over quantum expiry so a process
    // that finishes on its last allowed instruction is terminated, not saved.
    always_comb begin
        state_next = state_reg;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        case (state_reg)
            SO_RUN: begin
                if (bus.exec_proc) begin
                    state_next = LAUNCH;
                    timer_load = 1'b1;
                end
            end
            LAUNCH: begin
                state_next = PROC_RUN;
            end
            PROC_RUN: begin
                if (bus.halt_proc) begin
                    state_next = FINISH;
                end else if (bus.instr_retire && timer_expired) begin
                    state_next = PREEMPT;
                end else if (bus.instr_retire) begin
                    timer_dec = 1'b1;
                end
            end
            PREEMPT: state_next = SO_RUN;
            FINISH:  state_next = SO_RUN;
            default: state_next = SO_RUN;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg     <= SO_RUN;
            so_resume_reg <= '0;
            pc_next_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == SO_RUN) && bus.exec_proc) begin
                // Resume after the instruction that requested the launch;
                // wraps modulo 2^PC_WIDTH.
                so_resume_reg <= bus.ProgramCounter + PC_WIDTH'(1);
                pc_next_reg   <= bus.proc_entry;
            end else if ((state_next == PREEMPT) || (state_next == FINISH)) begin
                pc_next_reg <= so_resume_reg;
            end
        end
    end

    // Moore output decode.
    always_comb begin
        bus.select_proc_reg_read  = BANK_SO;
        bus.select_proc_reg_write = BANK_SO;
        bus.change_so             = 1'b0;
        bus.end_proc              = 1'b0;
        bus.pc_load               = 1'b0;
        if (reads_proc_bank(state_reg)) begin
            bus.select_proc_reg_read = BANK_PROC;
        end
        case (state_reg)
            LAUNCH: begin
                bus.select_proc_reg_write = BANK_PROC;
                bus.pc_load               = 1'b1;
            end
            PROC_RUN: begin
                bus.select_proc_reg_write = BANK_PROC;
            end
            PREEMPT: begin
                bus.select_proc_reg_write = BANK_PROC;
                bus.change_so             = 1'b1;
                bus.pc_load               = 1'b1;
            end
            FINISH: begin
                bus.select_proc_reg_write = BANK_PROC;
                bus.end_proc              = 1'b1;
                bus.pc_load               = 1'b1;
            end
            default: ;
        endcase
        bus.pc_next   = pc_next_reg;
        bus.user_mode = bus.select_proc_reg_read;
    end
endmodule

// File: tb/tb_process_switch_ctrl.sv
// Self-checking bench: two controllers (QUANTUM = 4 and QUANTUM = 1) driven
// with the same stimulus, compared each cycle against a behavioural model
// that counts retired instructions up to the quantum.
module tb_process_switch_ctrl;
    logic Clock;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    process_switch_ctrl_if #(.PC_WIDTH(32)) bus_a ();
    process_switch_ctrl_if #(.PC_WIDTH(32)) bus_b ();

    process_switch_ctrl #(.QUANTUM(4), .PC_WIDTH(32)) dut_a (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_a.slave)
    );

    process_switch_ctrl #(.QUANTUM(1), .PC_WIDTH(32)) dut_b (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_b.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural model. ev: 0 none, 1 launching, 2 preempting, 3 finishing.
    int          quantum [2] = '{4, 1};
    bit          m_user  [2];
    int          m_ev    [2];
    int          m_ret   [2];
    logic [31:0] m_res   [2];
    logic [31:0] m_pcn   [2];

    task automatic model_edge(input int k, input logic rst, input logic ex,
                              input logic [31:0] ent, input logic hl,
                              input logic rt, input logic [31:0] pc);
        if (rst) begin
            m_user[k] = 0; m_ev[k] = 0; m_ret[k] = 0;
            m_res[k] = 32'd0; m_pcn[k] = 32'd0;
        end else if (m_ev[k] == 1) begin
            m_ev[k] = 0;                       // retires during launch ignored
        end else if (m_ev[k] >= 2) begin
            m_ev[k] = 0; m_user[k] = 0;
        end else if (!m_user[k]) begin
            if (ex) begin
                m_res[k] = pc + 32'd1;
                m_pcn[k] = ent;
                m_user[k] = 1; m_ev[k] = 1; m_ret[k] = 0;
            end
        end else if (hl) begin
            m_ev[k] = 3; m_pcn[k] = m_res[k];
        end else if (rt) begin
            m_ret[k]++;
            if (m_ret[k] == quantum[k]) begin
                m_ev[k] = 2; m_pcn[k] = m_res[k];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string who, input int k,
                               input logic rd, input logic wr, input logic cs,
                               input logic ep, input logic pl, input logic [31:0] pn,
                               input logic um);
        logic e_rd;
        e_rd = m_user[k] && (m_ev[k] < 2);
        chk({who, ".read"},   {31'd0, rd}, {31'd0, e_rd});
        chk({who, ".write"},  {31'd0, wr}, {31'd0, m_user[k]});
        chk({who, ".change_so"}, {31'd0, cs}, {31'd0, m_ev[k] == 2});
        chk({who, ".end_proc"},  {31'd0, ep}, {31'd0, m_ev[k] == 3});
        chk({who, ".pc_load"},   {31'd0, pl}, {31'd0, m_ev[k] != 0});
        chk({who, ".pc_next"},   pn, m_pcn[k]);
        chk({who, ".user_mode"}, {31'd0, um}, {31'd0, e_rd});
        chk({who, ".strobe_excl"}, {31'd0, cs & ep}, 32'd0);
    endtask

    // One clock: drive inputs, take the edge, update model, compare.
    task automatic step(input logic rst, input logic ex, input logic [31:0] ent,
                        input logic hl, input logic rt, input logic [31:0] pc);
        Reset = rst;
        bus_a.exec_proc = ex; bus_a.proc_entry = ent; bus_a.halt_proc = hl;
        bus_a.instr_retire = rt; bus_a.ProgramCounter = pc;
        bus_b.exec_proc = ex; bus_b.proc_entry = ent; bus_b.halt_proc = hl;
        bus_b.instr_retire = rt; bus_b.ProgramCounter = pc;
        @(posedge Clock);
        for (int k = 0; k < 2; k++) model_edge(k, rst, ex, ent, hl, rt, pc);
        #1;
        check_model("A", 0, bus_a.select_proc_reg_read, bus_a.select_proc_reg_write,
                    bus_a.change_so, bus_a.end_proc, bus_a.pc_load, bus_a.pc_next,
                    bus_a.user_mode);
        check_model("B", 1, bus_b.select_proc_reg_read, bus_b.select_proc_reg_write,
                    bus_b.change_so, bus_b.end_proc, bus_b.pc_load, bus_b.pc_next,
                    bus_b.user_mode);
        $display("t=%0t rst=%0b exec=%0b halt=%0b ret=%0b pc=%h | A pcl=%0b pcn=%h rd=%0b wr=%0b cs=%0b ep=%0b | B pcl=%0b pcn=%h rd=%0b wr=%0b cs=%0b ep=%0b",
                 $time, rst, ex, hl, rt, pc,
                 bus_a.pc_load, bus_a.pc_next, bus_a.select_proc_reg_read,
                 bus_a.select_proc_reg_write, bus_a.change_so, bus_a.end_proc,
                 bus_b.pc_load, bus_b.pc_next, bus_b.select_proc_reg_read,
                 bus_b.select_proc_reg_write, bus_b.change_so, bus_b.end_proc);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'h1000);
    endtask

    initial begin
        Reset = 1'b1;
        bus_a.exec_proc = 0; bus_a.proc_entry = 0; bus_a.halt_proc = 0;
        bus_a.instr_retire = 0; bus_a.ProgramCounter = 0;
        bus_b.exec_proc = 0; bus_b.proc_entry = 0; bus_b.halt_proc = 0;
        bus_b.instr_retire = 0; bus_b.ProgramCounter = 0;

        // Reset state
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("reset.pc_next", bus_a.pc_next, 32'd0);
        chk("reset.write", {31'd0, bus_a.select_proc_reg_write}, 32'd0);

        // Launch from 0x40 to 0x200
        step(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h40);
        chk("launch.pc_load", {31'd0, bus_a.pc_load}, 32'd1);
        chk("launch.pc_next", bus_a.pc_next, 32'h200);
        chk("launch.read", {31'd0, bus_a.select_proc_reg_read}, 32'd1);
        chk("launch.write", {31'd0, bus_a.select_proc_reg_write}, 32'd1);
        // Retire during LAUNCH is not counted
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h200);
        // Quantum 4 on A: four retires, last at 0x204
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h201);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h202);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h203);
        chk("preempt.not_early", {31'd0, bus_a.change_so}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h204);
        chk("preempt.change_so", {31'd0, bus_a.change_so}, 32'd1);
        chk("preempt.write", {31'd0, bus_a.select_proc_reg_write}, 32'd1);
        chk("preempt.read", {31'd0, bus_a.select_proc_reg_read}, 32'd0);
        chk("preempt.pc_next", bus_a.pc_next, 32'h41);
        idle();
        chk("preempt.back_so", {31'd0, bus_a.select_proc_reg_write}, 32'd0);

        // Termination after two retires
        step(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h40);
        idle();
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h300);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h301);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h302);
        chk("finish.end_proc", {31'd0, bus_a.end_proc}, 32'd1);
        chk("finish.change_so", {31'd0, bus_a.change_so}, 32'd0);
        chk("finish.pc_next", bus_a.pc_next, 32'h41);
        idle();
        chk("finish.one_cycle", {31'd0, bus_a.end_proc}, 32'd0);

        // Collision on B (QUANTUM=1): halt and first retire together
        step(1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 32'h80);
        idle();
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h400);
        chk("collide.end_proc", {31'd0, bus_b.end_proc}, 32'd1);
        chk("collide.change_so", {31'd0, bus_b.change_so}, 32'd0);
        chk("collide.pc_next", bus_b.pc_next, 32'h81);
        idle();

        // Ignored inputs
        step(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h10);
        idle();
        step(1'b0, 1'b1, 32'h999, 1'b0, 1'b0, 32'h600);
        chk("ignore.exec_read", {31'd0, bus_a.select_proc_reg_read}, 32'd1);
        chk("ignore.exec_pcload", {31'd0, bus_a.pc_load}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h601);
        idle();
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h20);
        chk("ignore.halt_endproc", {31'd0, bus_a.end_proc}, 32'd0);
        chk("ignore.halt_write", {31'd0, bus_a.select_proc_reg_write}, 32'd0);

        // Resume PC wrap
        step(1'b0, 1'b1, 32'h700, 1'b0, 1'b0, 32'hFFFF_FFFF);
        idle();
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h700);
        chk("wrap.pc_load", {31'd0, bus_a.pc_load}, 32'd1);
        chk("wrap.pc_next", bus_a.pc_next, 32'd0);
        idle();

        // Reset held three cycles mid PROC_RUN
        step(1'b0, 1'b1, 32'h800, 1'b0, 1'b0, 32'h20);
        idle();
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h800);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h801);
        chk("rst_mid.read", {31'd0, bus_a.select_proc_reg_read}, 32'd0);
        chk("rst_mid.change_so", {31'd0, bus_a.change_so}, 32'd0);
        chk("rst_mid.end_proc", {31'd0, bus_a.end_proc}, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'h802);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'h803);
        chk("rst_mid.pc_next", bus_a.pc_next, 32'd0);
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom(),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
